// File: rtl/hilo_muldiv_if.sv
// Bundle between the execute stage, the HI/LO sequencer and the external
// multiplier/divider. The sequencer sits on the slave side.
interface hilo_muldiv_if;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic        mul_valid;
    logic        mul_signed;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [31:0] mul_hi;
    logic [31:0] mul_lo;
    logic        div_start;
    logic        div_cancel;
    logic        div_signed;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_done;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic [31:0] hi;
    logic [31:0] lo;

    modport slave (
        input  req_valid, req_op, req_a, req_b, flush,
        input  mul_hi, mul_lo, div_done, div_q, div_r,
        output busy, done, mul_valid, mul_signed, mul_a, mul_b,
        output div_start, div_cancel, div_signed, div_a, div_b, hi, lo
    );

    modport master (
        output req_valid, req_op, req_a, req_b, flush,
        output mul_hi, mul_lo, div_done, div_q, div_r,
        input  busy, done, mul_valid, mul_signed, mul_a, mul_b,
        input  div_start, div_cancel, div_signed, div_a, div_b, hi, lo
    );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO sequencer: issues MULT/MULTU to a fixed-latency multiplier and
// DIV/DIVU to a start/done divider, stalls execute while busy, and owns
// the architectural HI/LO registers (also written directly by MTHI/MTLO).
module hilo_muldiv_ctrl #(
    parameter int MULT_LAT = 3
) (
    input  logic          clk,
    input  logic          resetn,
    hilo_muldiv_if.slave  bus
);
    localparam int CW = $clog2(MULT_LAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DZ} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   opa_q, opa_d, opb_q, opb_d;
    logic          sgn_q, sgn_d;
    logic          done_q, done_d;
    logic          accept;

    // done_q blocks the still-held request in the commit cycle from re-issuing
    assign accept = (state_q == S_IDLE) && bus.req_valid && !bus.flush && !done_q;

    // next-state, counter, HI/LO and operand latch logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sgn_d   = sgn_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!bus.req_op[2]) begin
                        // ops 0..3: bit1 selects divide, bit0 selects unsigned
                        opa_d = bus.req_a;
                        opb_d = bus.req_b;
                        sgn_d = ~bus.req_op[0];
                        cnt_d = '0;
                        if (!bus.req_op[1]) begin
                            state_d = S_MUL;
                            cnt_d   = CW'(1);
                        end else if (bus.req_b == 32'd0) begin
                            state_d = S_DZ;
                        end else begin
                            state_d = S_DIV;
                        end
                    end else if (bus.req_op == 3'd4) begin
                        hi_d = bus.req_a;
                    end else if (bus.req_op == 3'd5) begin
                        lo_d = bus.req_a;
                    end
                end
            end
            S_MUL: begin
                if (cnt_q == CW'(MULT_LAT)) begin
                    hi_d    = bus.mul_hi;
                    lo_d    = bus.mul_lo;
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DIV: begin
                // non-zero count marks that the start pulse has been sent
                cnt_d = CW'(1);
                if (bus.div_done) begin
                    hi_d    = bus.div_r;
                    lo_d    = bus.div_q;
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
            S_DZ: begin
                // divide by zero leaves HI/LO untouched, just completes
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        // flush overrides everything, including a same-cycle completion
        if (bus.flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
        end
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            sgn_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sgn_q   <= sgn_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy       = (state_q != S_IDLE) | (bus.req_valid & ~bus.req_op[2] & ~done_q);
    assign bus.done       = done_q;
    assign bus.mul_valid  = (state_q == S_MUL);
    assign bus.mul_signed = sgn_q;
    assign bus.mul_a      = opa_q;
    assign bus.mul_b      = opb_q;
    assign bus.div_start  = (state_q == S_DIV) && (cnt_q == '0);
    assign bus.div_cancel = (state_q == S_DIV) && bus.flush;
    assign bus.div_signed = sgn_q;
    assign bus.div_a      = opa_q;
    assign bus.div_b      = opb_q;
    assign bus.hi         = hi_q;
    assign bus.lo         = lo_q;
endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl with small multiplier/divider models.
module tb_hilo_muldiv_ctrl;
    localparam int MULT_LAT = 3;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    hilo_muldiv_if u_if();

    hilo_muldiv_ctrl #(.MULT_LAT(MULT_LAT)) u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (u_if)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // multiplier model: product only presented once valid has been held MULT_LAT cycles
    int          mcnt = 0;
    logic [63:0] ea, eb, prod;
    logic        mok;
    always @(posedge clk or negedge resetn)
        if (!resetn) mcnt <= 0;
        else if (u_if.mul_valid) mcnt <= mcnt + 1;
        else mcnt <= 0;
    always_comb begin
        ea   = u_if.mul_signed ? {{32{u_if.mul_a[31]}}, u_if.mul_a} : {32'd0, u_if.mul_a};
        eb   = u_if.mul_signed ? {{32{u_if.mul_b[31]}}, u_if.mul_b} : {32'd0, u_if.mul_b};
        prod = ea * eb;
        mok  = u_if.mul_valid && (mcnt + 1 >= MULT_LAT);
    end
    assign u_if.mul_hi = mok ? prod[63:32] : 32'hDEADBEEF;
    assign u_if.mul_lo = mok ? prod[31:0]  : 32'hDEADBEEF;

    // divider model: div_done pulses div_lat cycles after the start cycle
    int          div_lat = 33;
    int          dcnt = 0;
    logic [31:0] dq = '0, dr = '0;
    always @(posedge clk or negedge resetn)
        if (!resetn) begin
            dcnt <= 0;
        end else if (u_if.div_cancel) begin
            dcnt <= 0;
        end else if (u_if.div_start) begin
            dcnt <= div_lat;
            if (u_if.div_signed) begin
                dq <= $signed(u_if.div_a) / $signed(u_if.div_b);
                dr <= $signed(u_if.div_a) % $signed(u_if.div_b);
            end else begin
                dq <= u_if.div_a / u_if.div_b;
                dr <= u_if.div_a % u_if.div_b;
            end
        end else if (dcnt > 0) begin
            dcnt <= dcnt - 1;
        end
    assign u_if.div_done = (dcnt == 1);
    assign u_if.div_q    = dq;
    assign u_if.div_r    = dr;

    // event monitors
    int          n_mul_start = 0;
    int          n_div_start = 0;
    logic        mv_d = 1'b0;
    logic        last_msgn = 1'b0, last_dsgn = 1'b0;
    logic [31:0] last_mula = '0;
    always @(posedge clk) begin
        mv_d <= u_if.mul_valid;
        if (u_if.mul_valid && !mv_d) n_mul_start <= n_mul_start + 1;
        if (u_if.mul_valid) begin
            last_msgn <= u_if.mul_signed;
            last_mula <= u_if.mul_a;
        end
        if (u_if.div_start) begin
            n_div_start <= n_div_start + 1;
            last_dsgn   <= u_if.div_signed;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        u_if.req_valid = 1'b0;
        u_if.req_op    = 3'd7;
        u_if.req_a     = '0;
        u_if.req_b     = '0;
        u_if.flush     = 1'b0;
    endtask

    // hold a request until done, counting cycles to done and busy cycles
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int nbusy);
        u_if.req_valid = 1'b1;
        u_if.req_op    = op;
        u_if.req_a     = a;
        u_if.req_b     = b;
        #1;
        lat = 0;
        nbusy = 0;
        while (u_if.done !== 1'b1 && lat < 200) begin
            if (u_if.busy === 1'b1) nbusy++;
            cyc(); #1;
            lat++;
        end
        if (lat >= 200) chk("op_timeout", 32'(u_if.done), 32'd1);
        chk("done_cycle_busy", 32'(u_if.busy), 32'd0);
        cyc();
        idle_inputs();
        #1;
        chk("post_done_done", 32'(u_if.done), 32'd0);
        chk("post_done_busy", 32'(u_if.busy), 32'd0);
    endtask

    task automatic mt(input logic [2:0] op, input logic [31:0] a);
        u_if.req_valid = 1'b1;
        u_if.req_op    = op;
        u_if.req_a     = a;
        u_if.req_b     = '0;
        #1;
        chk("mt_busy", 32'(u_if.busy), 32'd0);
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int lat, nb, n;
        idle_inputs();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hi", u_if.hi, 32'd0);
        chk("rst_lo", u_if.lo, 32'd0);
        chk("rst_busy", 32'(u_if.busy), 32'd0);
        chk("rst_done", 32'(u_if.done), 32'd0);
        chk("rst_mul_valid", 32'(u_if.mul_valid), 32'd0);
        chk("rst_div_start", 32'(u_if.div_start), 32'd0);
        chk("rst_mul_a", u_if.mul_a, 32'd0);
        resetn = 1'b1;
        cyc(); #1;

        // MULT -3 * 5
        issue(3'd0, 32'hFFFFFFFD, 32'h00000005, lat, nb);
        chk("mult_latency", lat, 4);
        chk("mult_busy_cycles", nb, 4);
        chk("mult_hi", u_if.hi, 32'hFFFFFFFF);
        chk("mult_lo", u_if.lo, 32'hFFFFFFF1);
        chk("mult_signed", 32'(last_msgn), 32'd1);
        chk("mult_opa", last_mula, 32'hFFFFFFFD);

        // MULTU max * max, request held through the done cycle
        issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, nb);
        cyc(); #1;
        chk("multu_latency", lat, 4);
        chk("multu_hi", u_if.hi, 32'hFFFFFFFE);
        chk("multu_lo", u_if.lo, 32'h00000001);
        chk("multu_signed", 32'(last_msgn), 32'd0);
        chk("mul_start_count", n_mul_start, 2);

        // DIV -7 / 2
        div_lat = 33;
        issue(3'd2, 32'hFFFFFFF9, 32'h00000002, lat, nb);
        cyc(); #1;
        chk("div_latency", lat, 35);
        chk("div_busy_cycles", nb, 35);
        chk("div_lo", u_if.lo, 32'hFFFFFFFD);
        chk("div_hi", u_if.hi, 32'hFFFFFFFF);
        chk("div_start_count", n_div_start, 1);
        chk("div_signed", 32'(last_dsgn), 32'd1);

        // DIVU by zero with HI preset
        mt(3'd4, 32'h12345678);
        idle_inputs(); #1;
        chk("mthi_pre", u_if.hi, 32'h12345678);
        issue(3'd3, 32'h00000005, 32'h00000000, lat, nb);
        cyc(); #1;
        chk("dz_latency", lat, 2);
        chk("dz_hi", u_if.hi, 32'h12345678);
        chk("dz_lo", u_if.lo, 32'hFFFFFFFD);
        chk("dz_no_start", n_div_start, 1);

        // MTHI then MTLO back-to-back
        mt(3'd4, 32'h0000ABCD);
        u_if.req_op = 3'd5;
        u_if.req_a  = 32'h00001234;
        #1;
        chk("mtlo_busy", 32'(u_if.busy), 32'd0);
        chk("mthi_hi", u_if.hi, 32'h0000ABCD);
        chk("mthi_lo_old", u_if.lo, 32'hFFFFFFFD);
        cyc();
        idle_inputs(); #1;
        chk("mtlo_lo", u_if.lo, 32'h00001234);
        chk("mt_done", 32'(u_if.done), 32'd0);

        // flush at cycle T+2 of a MULT
        u_if.req_valid = 1'b1;
        u_if.req_op    = 3'd0;
        u_if.req_a     = 32'd3;
        u_if.req_b     = 32'd4;
        cyc();
        cyc();
        u_if.flush = 1'b1;
        #1;
        chk("mflush_in_mul", 32'(u_if.mul_valid), 32'd1);
        cyc();
        idle_inputs(); #1;
        chk("mflush_idle", 32'(u_if.mul_valid), 32'd0);
        chk("mflush_busy", 32'(u_if.busy), 32'd0);
        chk("mflush_done", 32'(u_if.done), 32'd0);
        cyc(); #1;
        chk("mflush_done2", 32'(u_if.done), 32'd0);
        chk("mflush_hi", u_if.hi, 32'h0000ABCD);
        chk("mflush_lo", u_if.lo, 32'h00001234);

        // flush alongside IDLE requests: neither accepted
        u_if.req_valid = 1'b1;
        u_if.req_op    = 3'd5;
        u_if.req_a     = 32'h55555555;
        u_if.flush     = 1'b1;
        cyc();
        u_if.req_op = 3'd0;
        cyc();
        idle_inputs(); #1;
        chk("iflush_lo", u_if.lo, 32'h00001234);
        chk("iflush_no_mul", 32'(u_if.mul_valid), 32'd0);

        // flush in the same cycle as div_done
        div_lat = 5;
        u_if.req_valid = 1'b1;
        u_if.req_op    = 3'd2;
        u_if.req_a     = 32'd100;
        u_if.req_b     = 32'd7;
        #1;
        n = 0;
        while (u_if.div_done !== 1'b1 && n < 50) begin
            cyc(); #1;
            n++;
        end
        if (n >= 50) chk("dflush_timeout", 32'(u_if.div_done), 32'd1);
        u_if.flush = 1'b1;
        #1;
        chk("dflush_cancel", 32'(u_if.div_cancel), 32'd1);
        cyc();
        idle_inputs(); #1;
        chk("dflush_busy", 32'(u_if.busy), 32'd0);
        chk("dflush_done", 32'(u_if.done), 32'd0);
        chk("dflush_cancel_off", 32'(u_if.div_cancel), 32'd0);
        cyc(); #1;
        chk("dflush_done2", 32'(u_if.done), 32'd0);
        chk("dflush_hi", u_if.hi, 32'h0000ABCD);
        chk("dflush_lo", u_if.lo, 32'h00001234);

        // reset in the middle of a DIV
        div_lat = 33;
        u_if.req_valid = 1'b1;
        u_if.req_op    = 3'd2;
        u_if.req_a     = 32'hFFFFFFF9;
        u_if.req_b     = 32'd2;
        repeat (5) cyc();
        #1;
        chk("rdiv_busy", 32'(u_if.busy), 32'd1);
        idle_inputs();
        resetn = 1'b0;
        #1;
        chk("rdiv_hi", u_if.hi, 32'd0);
        chk("rdiv_lo", u_if.lo, 32'd0);
        chk("rdiv_busy0", 32'(u_if.busy), 32'd0);
        #2;
        resetn = 1'b1;
        cyc(); #1;
        chk("rdiv_after_busy", 32'(u_if.busy), 32'd0);
        chk("rdiv_after_done", 32'(u_if.done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
